// File: rtl/nios2_oci_trace_capture.sv
// Trace capture buffer: records debug trace words into a ring, then drains them oldest-first.
// state   | meaning
// CAPTURE | accept qualified trace words into the ring buffer
// DRAIN   | present stored entries on rd_* until the buffer is empty
// DONE    | capture stopped and buffer drained; held until reset
module nios2_oci_trace_capture #(
  parameter int DATA_W    = 30,
  parameter int CNT_W     = 4,
  parameter int DEPTH     = 16,
  parameter int WRAP_MODE = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_W-1:0]        dct_buffer,
  input  logic [CNT_W-1:0]         dct_count,
  input  logic                     dct_valid,
  input  logic                     test_ending,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic [CNT_W-1:0]         rd_count,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  output logic                     test_has_ended
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int EW = CNT_W + DATA_W;

  typedef enum logic [1:0] {ST_CAPTURE, ST_DRAIN, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic            overflow_q, overflow_d;
  logic            mem_we;
  logic            full;
  logic [EW-1:0]   head;
  logic [EW-1:0]   mem_q [DEPTH];

  assign full = (fill_q == FW'(DEPTH));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    rd_valid   = (state_q == ST_DRAIN) && (fill_q != '0);
    unique case (state_q)
      ST_CAPTURE: begin
        if (dct_valid && (dct_count != '0)) begin
          if (!full) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            fill_d   = fill_q + FW'(1);
          end else begin
            overflow_d = 1'b1;
            // Overwrite mode drops the oldest entry by moving both pointers together.
            if (WRAP_MODE != 0) begin
              mem_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + AW'(1);
              rd_ptr_d = rd_ptr_q + AW'(1);
            end
          end
        end
        if (test_ending) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fill_q == '0) begin
          state_d = ST_DONE;
        end else if (rd_ready) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          fill_d   = fill_q - FW'(1);
        end
      end
      ST_DONE: begin
      end
      default: state_d = ST_CAPTURE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_CAPTURE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is unreset; rd_valid gating keeps stale contents off the outputs.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= {dct_count, dct_buffer};
  end

  assign head           = mem_q[rd_ptr_q];
  assign rd_data        = rd_valid ? head[DATA_W-1:0] : '0;
  assign rd_count       = rd_valid ? head[EW-1:DATA_W] : '0;
  assign fill_level     = fill_q;
  assign overflow       = overflow_q;
  assign test_has_ended = (state_q == ST_DONE);

endmodule

// File: tb/tb_nios2_oci_trace_capture.sv
// Bench for nios2_oci_trace_capture: runs stop-on-full and overwrite instances side by side
// against a queue-based reference model, plus a table of hand-derived vectors.
module tb_nios2_oci_trace_capture;
  localparam int DW = 30;
  localparam int CW = 4;
  localparam int DEPTH = 16;
  localparam int MS_CAP = 0, MS_DRAIN = 1, MS_DONE = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [DW-1:0] dct_buffer = '0;
  logic [CW-1:0] dct_count = '0;
  logic          dct_valid = 1'b0;
  logic          test_ending = 1'b0;
  logic          rd_ready = 1'b0;

  logic          rd_valid [2];
  logic [DW-1:0] rd_data [2];
  logic [CW-1:0] rd_count [2];
  logic [4:0]    fill_level [2];
  logic          overflow [2];
  logic          test_has_ended [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    nios2_oci_trace_capture #(.DATA_W(DW), .CNT_W(CW), .DEPTH(DEPTH), .WRAP_MODE(g)) u_dut (
      .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
      .dct_valid(dct_valid), .test_ending(test_ending), .rd_ready(rd_ready),
      .rd_valid(rd_valid[g]), .rd_data(rd_data[g]), .rd_count(rd_count[g]),
      .fill_level(fill_level[g]), .overflow(overflow[g]), .test_has_ended(test_has_ended[g])
    );
  end

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [CW+DW-1:0] sbq [2][$];
  int   mstate [2];
  logic movf [2];

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    bit v, te, rdy;
    int fill;
    bit rv, ended;
  } vec_t;
  vec_t tbl [9];
  bit   pat [4];

  function automatic logic [DW-1:0] dat(input int i);
    return DW'(32'h0100 + i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_now();
    for (int w = 0; w < 2; w++) begin
      bit ev;
      logic [CW+DW-1:0] h;
      ev = (mstate[w] == MS_DRAIN) && (sbq[w].size() != 0);
      chk($sformatf("rd_valid[%0d]", w), 64'(rd_valid[w]), 64'(ev));
      chk($sformatf("fill_level[%0d]", w), 64'(fill_level[w]), 64'(sbq[w].size()));
      chk($sformatf("overflow[%0d]", w), 64'(overflow[w]), 64'(movf[w]));
      chk($sformatf("test_has_ended[%0d]", w), 64'(test_has_ended[w]), 64'(mstate[w] == MS_DONE));
      if (ev) begin
        h = sbq[w][0];
        chk($sformatf("rd_data[%0d]", w), 64'(rd_data[w]), 64'(h[DW-1:0]));
        chk($sformatf("rd_count[%0d]", w), 64'(rd_count[w]), 64'(h[CW+DW-1:DW]));
      end
    end
  endtask

  task automatic model_step();
    for (int w = 0; w < 2; w++) begin
      case (mstate[w])
        MS_CAP: begin
          if (dct_valid && dct_count != '0) begin
            if (sbq[w].size() < DEPTH) begin
              sbq[w].push_back({dct_count, dct_buffer});
            end else begin
              movf[w] = 1'b1;
              if (w == 1) begin
                void'(sbq[w].pop_front());
                sbq[w].push_back({dct_count, dct_buffer});
              end
            end
          end
          if (test_ending) mstate[w] = MS_DRAIN;
        end
        MS_DRAIN: begin
          if (sbq[w].size() == 0) mstate[w] = MS_DONE;
          else if (rd_ready) void'(sbq[w].pop_front());
        end
        default: ;
      endcase
    end
  endtask

  task automatic step();
    check_now();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input bit te, input bit rdy);
    dct_valid = v; dct_buffer = d; dct_count = c; test_ending = te; rd_ready = rdy;
  endtask

  task automatic wr(input logic [DW-1:0] d, input logic [CW-1:0] c, input bit te);
    drive(1'b1, d, c, te, 1'b0);
    step();
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("rst rd_valid[%0d]", w), 64'(rd_valid[w]), 64'd0);
      chk($sformatf("rst rd_data[%0d]", w), 64'(rd_data[w]), 64'd0);
      chk($sformatf("rst rd_count[%0d]", w), 64'(rd_count[w]), 64'd0);
      chk($sformatf("rst fill_level[%0d]", w), 64'(fill_level[w]), 64'd0);
      chk($sformatf("rst overflow[%0d]", w), 64'(overflow[w]), 64'd0);
      chk($sformatf("rst test_has_ended[%0d]", w), 64'(test_has_ended[w]), 64'd0);
      sbq[w].delete();
      mstate[w] = MS_CAP;
      movf[w] = 1'b0;
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic drain_until_done(input bit bp);
    int k;
    k = 0;
    while (k < 80 && !(mstate[0] == MS_DONE && mstate[1] == MS_DONE)) begin
      drive(1'b0, '0, '0, 1'b0, bp ? pat[k % 4] : 1'b1);
      step();
      k++;
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    step();
    chk("done held[0]", 64'(test_has_ended[0]), 64'd1);
    chk("done held[1]", 64'(test_has_ended[1]), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    //           data          cnt  v  te rdy fill rv ended
    tbl[0] = '{30'h0AAA_0001, 4'd1, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{30'h0BBB_0002, 4'd2, 1, 0, 0, 1, 0, 0};
    tbl[2] = '{30'h0CCC_0003, 4'd3, 1, 0, 0, 2, 0, 0};
    tbl[3] = '{30'h0,         4'd0, 0, 1, 0, 3, 0, 0};
    tbl[4] = '{30'h0,         4'd0, 0, 0, 1, 3, 1, 0};
    tbl[5] = '{30'h0,         4'd0, 0, 0, 1, 2, 1, 0};
    tbl[6] = '{30'h0,         4'd0, 0, 0, 1, 1, 1, 0};
    tbl[7] = '{30'h0,         4'd0, 0, 0, 1, 0, 0, 0};
    tbl[8] = '{30'h0,         4'd0, 0, 0, 1, 0, 0, 1};

    #2;
    do_reset();

    // Basic write-then-drain against fixed expectations.
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].te, tbl[i].rdy);
      for (int w = 0; w < 2; w++) begin
        chk($sformatf("tbl%0d fill[%0d]", i, w), 64'(fill_level[w]), 64'(tbl[i].fill));
        chk($sformatf("tbl%0d rv[%0d]", i, w), 64'(rd_valid[w]), 64'(tbl[i].rv));
        chk($sformatf("tbl%0d ended[%0d]", i, w), 64'(test_has_ended[w]), 64'(tbl[i].ended));
      end
      step();
    end

    // Full buffer: stop-on-full keeps 0..15, overwrite keeps 4..19.
    do_reset();
    for (int i = 0; i < 20; i++) wr(dat(i), CW'((i % 15) + 1), 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("full fill[%0d]", w), 64'(fill_level[w]), 64'd16);
      chk($sformatf("full overflow[%0d]", w), 64'(overflow[w]), 64'd1);
    end
    step();
    chk("full head stop", 64'(rd_data[0]), 64'(dat(0)));
    chk("full head wrap", 64'(rd_data[1]), 64'(dat(4)));
    drain_until_done(1'b0);

    // Zero-count ignored, write with test_ending kept, writes during drain ignored.
    do_reset();
    wr(dat(50), 4'd0, 1'b0);
    wr(dat(51), 4'd5, 1'b1);
    wr(dat(52), 4'd6, 1'b1);
    chk("edge fill", 64'(fill_level[0]), 64'd1);
    chk("edge head", 64'(rd_data[0]), 64'(dat(51)));
    drain_until_done(1'b0);

    // Empty buffer at test end.
    do_reset();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("empty ended c+1", 64'(test_has_ended[0]), 64'd0);
    step();
    chk("empty ended c+2", 64'(test_has_ended[0]), 64'd1);
    step();

    // Backpressure with rd_ready pattern 1,0,0,1.
    do_reset();
    for (int i = 0; i < 4; i++) wr(dat(60 + i), CW'(i + 7), 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    drain_until_done(1'b1);

    // Reset in the middle of a drain, then a fresh capture.
    do_reset();
    for (int i = 0; i < 5; i++) wr(dat(70 + i), CW'(i + 1), 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    step();
    step();
    chk("mid-drain fill", 64'(fill_level[0]), 64'd3);
    do_reset();
    wr(dat(80), 4'd9, 1'b0);
    wr(dat(81), 4'd10, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("resume fill", 64'(fill_level[0]), 64'd2);
    chk("resume rv", 64'(rd_valid[0]), 64'd0);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    chk("resume head", 64'(rd_data[0]), 64'(dat(80)));
    drain_until_done(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nios2_oci_trace_capture.md
NIOS2_OCI_TRACE_CAPTURE -- requirements
Module: nios2_oci_trace_capture

Interface
REQ-001 The block SHALL have parameter DATA_W, default 30, width of the debug capture trace word.
REQ-002 The block SHALL have parameter CNT_W, default 4, width of the per-word frame count.
REQ-003 The block SHALL have parameter DEPTH, default 16, number of stored entries (power of two, 2 to 1024).
REQ-004 The block SHALL have parameter WRAP_MODE, default 0: 0 = stop on full, 1 = overwrite oldest.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-007 The block SHALL have port dct_buffer, input, DATA_W, the trace word to capture.
REQ-008 The block SHALL have port dct_count, input, CNT_W, the number of valid frames in dct_buffer.
REQ-009 The block SHALL have port dct_valid, input, 1, which qualifies dct_buffer/dct_count for one cycle.
REQ-010 The block SHALL have port test_ending, input, 1, a request to stop capture and start drain.
REQ-011 The block SHALL have port rd_ready, input, 1, the drain-side consumer ready.
REQ-012 The block SHALL have port rd_valid, output, 1, a head entry available for drain.
REQ-013 The block SHALL have port rd_data, output, DATA_W, the head entry trace word.
REQ-014 The block SHALL have port rd_count, output, CNT_W, the head entry frame count.
REQ-015 The block SHALL have port fill_level, output, clog2(DEPTH)+1, the number of stored entries.
REQ-016 The block SHALL have port overflow, output, 1, a sticky flag: an entry was dropped or overwritten.
REQ-017 The block SHALL have port test_has_ended, output, 1, meaning capture stopped and buffer fully drained.

Function
REQ-018 The block SHALL implement state machine CAPTURE -> DRAIN -> DONE with no other transitions except reset.
REQ-019 In CAPTURE, a cycle with dct_valid=1 and dct_count!=0 SHALL write {dct_count,dct_buffer} at the write pointer; dct_count=0 SHALL be ignored.
REQ-020 A write SHALL be reflected in fill_level and rd_valid on the following cycle (latency 1).
REQ-021 On a write when full with WRAP_MODE=0, the entry SHALL be discarded, pointers and fill_level SHALL stay unchanged, and overflow SHALL be set.
REQ-022 On a write when full with WRAP_MODE=1, the oldest entry SHALL be overwritten, both pointers SHALL advance, fill_level SHALL stay DEPTH, and overflow SHALL be set.
REQ-023 Pointers SHALL wrap modulo DEPTH; fill_level SHALL never exceed DEPTH.
REQ-024 When test_ending=1 in CAPTURE, the block SHALL enter DRAIN next cycle, and a valid write in that same cycle SHALL still be captured.
REQ-025 In CAPTURE and DONE, rd_valid SHALL be 0.
REQ-026 dct_valid SHALL be ignored in DRAIN and DONE.
REQ-027 In DRAIN, rd_valid SHALL equal (fill_level!=0), and rd_data/rd_count SHALL present the oldest entry.
REQ-028 A transfer SHALL occur on rd_valid=1 and rd_ready=1; the read pointer SHALL advance and fill_level SHALL decrement next cycle.
REQ-029 rd_data/rd_count SHALL remain stable while rd_valid=1 and rd_ready=0.
REQ-030 In DRAIN with fill_level=0, the block SHALL enter DONE next cycle, including when DRAIN is entered with an empty buffer.
REQ-031 test_has_ended SHALL be 1 exactly while in DONE, and DONE SHALL be held until reset.
REQ-032 test_ending SHALL be ignored in DRAIN and DONE.
REQ-033 overflow SHALL be sticky until reset.

Reset
REQ-034 reset_n=0 SHALL immediately force state CAPTURE, clear both pointers, and set fill_level=0, overflow=0, rd_valid=0, test_has_ended=0, rd_data=0 and rd_count=0, including in mid-drain.
REQ-035 Memory contents SHALL need no reset; stale entries SHALL never be presented because rd_valid=0 when empty.

Verification
REQ-036 Basic: write 3 entries (counts 1,2,3), pulse test_ending, rd_ready=1 -> rd_data appears in write order, fill_level goes 3,2,1,0, test_has_ended=1 two cycles after the last transfer.
REQ-037 Full, WRAP_MODE=0, DEPTH=16: write 20 entries -> fill_level=16, overflow=1, drain yields entries 0..15.
REQ-038 Full, WRAP_MODE=1, DEPTH=16: write 20 entries -> fill_level=16, overflow=1, drain yields entries 4..19.
REQ-039 Edge cases: dct_count=0 writes are not stored; a write coinciding with test_ending is stored; test_ending with an empty buffer gives test_has_ended=1 two cycles later.
REQ-040 Backpressure: drain with rd_ready toggling 1,0,0,1 -> no loss or duplication, and rd_data is stable while stalled.
REQ-041 Reset mid-drain: after 2 of 5 entries drained, reset_n=0 for 1 cycle -> all outputs are 0 and capture resumes from empty.
